// File: rtl/regfile_wb_checker.sv
// +--------------------------------------------------------------------------------+
// | regfile_wb_checker: in-order writeback checker against a table of (rd, value)   |
// | Rev 1.0 -- optional macro WB_CHECK_MASK_EN adds a per-entry data compare mask   |
// +--------------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_checker #(
  parameter  int XLEN    = 32,
  parameter  int NREGS   = 32,
  parameter  int DEPTH   = 8,
  parameter  int TIMEOUT = 1024,
  localparam int RW      = $clog2(NREGS),
  localparam int PW      = $clog2(DEPTH + 1),
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            load_valid,
  input  logic [RW-1:0]   load_rd,
  input  logic [XLEN-1:0] load_data,
`ifdef WB_CHECK_MASK_EN
  input  logic [XLEN-1:0] load_mask,
`endif
  output logic            load_ready,
  input  logic            start,
  input  logic            wb_en,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [PW-1:0]   mismatch_idx,
  output logic [RW-1:0]   mismatch_rd,
  output logic [XLEN-1:0] mismatch_data,
  output logic [CW-1:0]   cycle_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   count;
  logic [PW-1:0]   ptr;

  logic [RW-1:0]   exp_rd   [DEPTH];
  logic [XLEN-1:0] exp_data [DEPTH];
`ifdef WB_CHECK_MASK_EN
  logic [XLEN-1:0] exp_mask [DEPTH];
`endif

  logic            w_load;
  logic [RW-1:0]   w_cur_rd;
  logic [XLEN-1:0] w_cur_data;
  logic [XLEN-1:0] w_cur_mask;
  logic [PW-1:0]   w_ptr_next;
  logic [CW-1:0]   w_cc_next;
  logic            w_observed;
  logic            w_match;

  assign load_ready = (state == S_IDLE) && (count < PW'(DEPTH));
  // start and clear both outrank a load offered on the same edge
  assign w_load     = load_valid && load_ready && !clear && !start;

  assign w_cur_rd   = exp_rd[ptr[AW-1:0]];
  assign w_cur_data = exp_data[ptr[AW-1:0]];
`ifdef WB_CHECK_MASK_EN
  assign w_cur_mask = exp_mask[ptr[AW-1:0]];
`else
  assign w_cur_mask = '1;
`endif

  assign w_ptr_next = ptr + PW'(1);
  assign w_cc_next  = cycle_count + CW'(1);
  assign w_observed = wb_en && (wb_rd != '0);
  assign w_match    = (wb_rd == w_cur_rd) &&
                      ((wb_data & w_cur_mask) == (w_cur_data & w_cur_mask));

  assign busy    = (state == S_RUN);
  assign done    = (state == S_PASS) || (state == S_FAIL) || (state == S_TIMEOUT);
  assign pass    = (state == S_PASS);
  assign timeout = (state == S_TIMEOUT);

  // Table storage carries no reset; count alone defines which entries are valid
  always_ff @(posedge clk) begin
    if (w_load) begin
      exp_rd[count[AW-1:0]]   <= load_rd;
      exp_data[count[AW-1:0]] <= load_data;
`ifdef WB_CHECK_MASK_EN
      exp_mask[count[AW-1:0]] <= load_mask;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      count         <= '0;
      ptr           <= '0;
      cycle_count   <= '0;
      mismatch_idx  <= '0;
      mismatch_rd   <= '0;
      mismatch_data <= '0;
    end else if (clear) begin
      state <= S_IDLE;
      count <= '0;
    end else if (start && (state != S_RUN)) begin
      ptr           <= '0;
      cycle_count   <= '0;
      mismatch_idx  <= '0;
      mismatch_rd   <= '0;
      mismatch_data <= '0;
      state         <= (count != '0) ? S_RUN : S_PASS;
    end else begin
      case (state)
        S_IDLE: begin
          if (w_load) count <= count + PW'(1);
        end
        S_RUN: begin
          if (w_observed && !w_match) begin
            state         <= S_FAIL;
            mismatch_idx  <= ptr;
            mismatch_rd   <= wb_rd;
            mismatch_data <= wb_data;
          end else if (w_observed && (w_ptr_next == count)) begin
            ptr   <= w_ptr_next;
            state <= S_PASS;
          end else begin
            // No verdict this edge: advance on a matching write and age the run
            cycle_count <= w_cc_next;
            if (w_observed) ptr <= w_ptr_next;
            if (w_cc_next == CW'(TIMEOUT)) begin
              state        <= S_TIMEOUT;
              mismatch_idx <= w_observed ? w_ptr_next : ptr;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_checker.sv
// +--------------------------------------------------------------------------------+
// | tb_regfile_wb_checker: directed vectors for regfile_wb_checker (TIMEOUT = 16)   |
// | Rev 1.0 -- mask vectors are built only with WB_CHECK_MASK_EN defined            |
// +--------------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_wb_checker;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int PW   = 4;
  localparam int CW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            clear;
  logic            load_valid;
  logic [RW-1:0]   load_rd;
  logic [XLEN-1:0] load_data;
`ifdef WB_CHECK_MASK_EN
  logic [XLEN-1:0] load_mask;
`endif
  logic            load_ready;
  logic            start;
  logic            wb_en;
  logic [RW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            busy;
  logic            done;
  logic            pass;
  logic            timeout;
  logic [PW-1:0]   mismatch_idx;
  logic [RW-1:0]   mismatch_rd;
  logic [XLEN-1:0] mismatch_data;
  logic [CW-1:0]   cycle_count;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wb_checker #(
    .XLEN(XLEN), .NREGS(32), .DEPTH(8), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data),
`ifdef WB_CHECK_MASK_EN
    .load_mask(load_mask),
`endif
    .load_ready(load_ready), .start(start),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .mismatch_idx(mismatch_idx), .mismatch_rd(mismatch_rd),
    .mismatch_data(mismatch_data), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [RW-1:0] rd, input logic [XLEN-1:0] data);
    load_valid = 1'b1; load_rd = rd; load_data = data;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wb(input logic [RW-1:0] rd, input logic [XLEN-1:0] data);
    wb_en = 1'b1; wb_rd = rd; wb_data = data;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load_valid = 1'b0; load_rd = '0; load_data = '0;
    start = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
`ifdef WB_CHECK_MASK_EN
    load_mask = '1;
`endif
    tick(); tick();
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_pass",  32'(pass), 0);
    check("rst_ready", 32'(load_ready), 1);
    check("rst_cc",    32'(cycle_count), 0);
    reset = 1'b0;
    tick();

    // ADDI x1,x1,22 -> 23 ; ANDI x2,x1,18 -> 23 & 18 = 18
    load(5'd1, 32'd23);
    load(5'd2, 32'd18);
    go();
    check("p1_busy", 32'(busy), 1);
    tick();
    wb(5'd1, 32'd23);
    check("p1_mid_busy", 32'(busy), 1);
    wb(5'd2, 32'd18);
    check("p1_pass", 32'(pass), 1);
    check("p1_done", 32'(done), 1);
    check("p1_cc",   32'(cycle_count), 2);
    check("p1_midx", 32'(mismatch_idx), 0);
    check("p1_mrd",  32'(mismatch_rd), 0);
    check("p1_mdat", mismatch_data, 0);

    // Same program against a wrong expectation for x2
    do_clear();
    load(5'd1, 32'd23);
    load(5'd2, 32'd19);
    go();
    tick();
    wb(5'd1, 32'd23);
    wb(5'd2, 32'd18);
    check("f_done", 32'(done), 1);
    check("f_pass", 32'(pass), 0);
    check("f_to",   32'(timeout), 0);
    check("f_midx", 32'(mismatch_idx), 1);
    check("f_mrd",  32'(mismatch_rd), 2);
    check("f_mdat", mismatch_data, 32'h12);
    check("f_cc",   32'(cycle_count), 2);

    // No writebacks at all: 16 RUN cycles then timeout
    do_clear();
    load(5'd1, 32'd5);
    go();
    for (int i = 0; i < 15; i++) tick();
    check("t_busy15", 32'(busy), 1);
    check("t_cc15",   32'(cycle_count), 15);
    tick();
    check("t_to",   32'(timeout), 1);
    check("t_pass", 32'(pass), 0);
    check("t_done", 32'(done), 1);
    check("t_midx", 32'(mismatch_idx), 0);
    check("t_cc",   32'(cycle_count), 16);
    tick(); tick();
    check("t_cc_hold", 32'(cycle_count), 16);

    // x0 writes are invisible to the checker; table survives a re-run
    do_clear();
    load(5'd1, 32'd7);
    go();
    wb(5'd0, 32'hDEAD);
    check("x0_busy", 32'(busy), 1);
    wb(5'd1, 32'd7);
    check("x0_pass", 32'(pass), 1);
    go();
    check("rerun_busy", 32'(busy), 1);
    wb(5'd1, 32'd7);
    check("rerun_pass", 32'(pass), 1);

    // DEPTH+1 offers: ninth is dropped
    do_clear();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("ready_%0d", i), 32'(load_ready), (i < 8) ? 1 : 0);
      load(RW'(i + 1), 32'(i * 3));
    end
    check("full_ready", 32'(load_ready), 0);
    go();
    for (int i = 0; i < 8; i++) wb(RW'(i + 1), 32'(i * 3));
    check("full_pass", 32'(pass), 1);

    do_clear();
    go();
    check("empty_pass", 32'(pass), 1);
    check("empty_busy", 32'(busy), 0);

    // Asynchronous reset while running
    do_clear();
    load(5'd1, 32'd1);
    go();
    check("ar_busy_pre", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_done", 32'(done), 0);
    check("ar_ready", 32'(load_ready), 1);
    tick();
    reset = 1'b0;
    tick();

`ifdef WB_CHECK_MASK_EN
    load_mask = 32'hF0;
    load(5'd1, 32'h15);
    load_mask = '1;
    go();
    wb(5'd1, 32'h1A);
    check("mask_pass", 32'(pass), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb_checker.md
# regfile_wb_checker

Synthesizable, parametrised self-checking monitor for the RV32I core. It holds a table of up to DEPTH expected register writebacks (rd, value), watches the core's writeback port, and compares each non-x0 write in program order. It reports pass, fail or timeout with the failing entry and value captured. It sits beside `core` on the writeback bus in regression harnesses and on FPGA bring-up builds, replacing `$monitor`-based manual checking.

## Interface
- XLEN, 32, data width of writeback values
- NREGS, 32, architectural register count; RW = $clog2(NREGS)
- DEPTH, 8, maximum expected-entry count; PW = $clog2(DEPTH+1)
- TIMEOUT, 1024, RUN cycles allowed before timeout; CW = $clog2(TIMEOUT+1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous: empty table, go to IDLE
- load_valid  in  1  expected entry offered
- load_rd  in  RW  expected destination register
- load_data  in  XLEN  expected value
- load_ready  out  1  high in IDLE while count < DEPTH
- start  in  1  begin checking (IDLE/PASS/FAIL/TIMEOUT)
- wb_en  in  1  core register write strobe
- wb_rd  in  RW  core destination register
- wb_data  in  XLEN  core write value
- busy  out  1  state == RUN
- done  out  1  state in {PASS, FAIL, TIMEOUT}
- pass  out  1  state == PASS
- timeout  out  1  state == TIMEOUT
- mismatch_idx  out  PW  entry index at failure/timeout
- mismatch_rd  out  RW  offending wb_rd (FAIL only)
- mismatch_data  out  XLEN  offending wb_data (FAIL only)
- cycle_count  out  CW  RUN cycles elapsed

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. Reset → IDLE; count, ptr, cycle_count, all mismatch_* = 0; all flags 0.
- IDLE: load_valid && load_ready writes entry[count], count++. Loads with count == DEPTH are dropped (load_ready = 0).
- start (any non-RUN state): ptr ← 0, cycle_count ← 0, mismatch_* ← 0. → RUN if count > 0, else → PASS directly. The table is kept, so a re-run repeats the same expectations.
- RUN, on each edge:
  - wb_en with wb_rd == 0: ignored.
  - wb_en with wb_rd != 0: compare against entry[ptr].
    - rd and data match: ptr++. If ptr+1 == count → PASS.
    - Otherwise → FAIL and capture mismatch_idx = ptr, wb_rd, wb_data.
  - Without a verdict, cycle_count++. If cycle_count+1 == TIMEOUT → TIMEOUT with mismatch_idx = ptr.
- Writebacks after the table is exhausted are not observed (state has left RUN).
- clear: → IDLE, count ← 0, flags drop. clear has priority over start, which has priority over load.
- start and load_valid are ignored while in RUN. clear in RUN aborts.

## Timing
- Load: accepted on the edge with load_valid && load_ready. load_ready reflects the new count on the next cycle.
- Start: busy rises on the edge after start is sampled.
- Verdict latency is 1 cycle. The edge that samples the final matching or mismatching wb_en sets done/pass/FAIL, so they are visible in the following cycle.
- Simultaneous compare and timeout on the same edge: the compare result wins.
- cycle_count freezes on leaving RUN and holds until the next start.
- Reset asserted mid-RUN: all outputs return to reset values immediately (asynchronously).

## Configuration
- Macro WB_CHECK_MASK_EN.
  - Defined: adds port load_mask in XLEN, stored per entry. The data match is (wb_data & mask) == (exp & mask). rd is always compared exactly.
  - Undefined: no load_mask port, no mask storage; full-width equality.

## Test plan
- Core regs preloaded x[k]=k. Load {(x1,23),(x2,18)}, start, program ADDI x1,x1,22; ANDI x2,x1,18 → PASS, cycle_count = 2, mismatch_* = 0.
- Same program, table {(x1,23),(x2,19)} → FAIL, mismatch_idx = 1, mismatch_rd = 2, mismatch_data = 0x12.
- Load 1 entry, start, drive no wb_en, TIMEOUT = 16 → timeout after 16 RUN cycles, mismatch_idx = 0, pass = 0.
- wb_en to x0 with data 0xDEAD interleaved before a correct x1 write → ignored, PASS.
- Offer DEPTH+1 loads → load_ready low after DEPTH accepted; extra entry dropped. start with empty table after clear → PASS next cycle.
- reset asserted mid-RUN → busy and flags low immediately; with WB_CHECK_MASK_EN, mask 0xF0, exp 0x15, wb 0x1A → PASS.
